// File: rtl/dtree_pkg.sv
// Shared types for the dtree class binner: default widths,
// bin index type and readout FSM states.
package dtree_pkg;

  localparam int DEF_LEVEL_WIDTH = 2;
  localparam int DEF_PATH_WIDTH  = 2;
  localparam int DEF_BIN_WIDTH   =
    DEF_LEVEL_WIDTH + DEF_PATH_WIDTH;

  typedef logic [DEF_BIN_WIDTH-1:0] bin_idx_t;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

endpackage

// File: rtl/dtree_class_binner_if.sv
// Histogram readout stream: one word per class, valid/ready.
// master drives index/count/valid/last, slave drives ready.
interface dtree_class_binner_if #(
  parameter int BIN_WIDTH   = 4,
  parameter int COUNT_WIDTH = 8
);

  logic [BIN_WIDTH-1:0]   bin_index;
  logic [COUNT_WIDTH-1:0] bin_count;
  logic                   bin_valid;
  logic                   bin_last;
  logic                   bin_ready;

  modport master (
    output bin_index,
    output bin_count,
    output bin_valid,
    output bin_last,
    input  bin_ready
  );

  modport slave (
    input  bin_index,
    input  bin_count,
    input  bin_valid,
    input  bin_last,
    output bin_ready
  );

endinterface

// File: rtl/dtree_sat_counter.sv
// Saturating per-class counter with synchronous clear.
// count_next is the value including this cycle's inc (for snapshots).
module dtree_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] count;

  // A clear and an event in the same cycle: the event
  // belongs to the fresh window.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = inc ? WIDTH'(1) : '0;
    end else if (inc && (count != '1)) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_next;
  end

endmodule

// File: rtl/dtree_class_binner.sv
// Counts dtree spikes per class over a tick window, snapshots
// the histogram and streams it out while the next window counts.
module dtree_class_binner
  import dtree_pkg::*;
#(
  parameter int LEVEL_WIDTH = DEF_LEVEL_WIDTH,
  parameter int PATH_WIDTH  = DEF_PATH_WIDTH,
  parameter int COUNT_WIDTH = 8,
  parameter int WINDOW_LEN  = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [LEVEL_WIDTH-1:0] level,
  input  logic [PATH_WIDTH-1:0]  path,
  input  logic                   in_valid,
  output logic                   overrun,
  dtree_class_binner_if.master   bin_if
);

  localparam int BIN_WIDTH = LEVEL_WIDTH + PATH_WIDTH;
  localparam int NUM_BINS  = 2 ** BIN_WIDTH;
  localparam int WIN_WIDTH = $clog2(WINDOW_LEN);

  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  logic [BIN_WIDTH-1:0] cls;
  logic [WIN_WIDTH-1:0] wcnt;
  logic                 window_end;
  logic                 clr;
  cnt_t                 live_nx [NUM_BINS];
  cnt_t                 shadow  [NUM_BINS];

  state_t               state, state_nx;
  logic [BIN_WIDTH-1:0] idx, idx_nx;
  logic                 last, xfer, load, ovr_nx;

  assign cls = {level, path};

  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_live
    dtree_sat_counter #(
      .WIDTH(COUNT_WIDTH)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (in_valid && (cls == BIN_WIDTH'(gi))),
      .clr       (clr),
      .count_next(live_nx[gi])
    );
  end

  assign window_end =
    tick && (wcnt == WIN_WIDTH'(WINDOW_LEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= '0;
      clr  <= 1'b0;
    end else begin
      clr <= window_end;
      if (window_end) wcnt <= '0;
      else if (tick)  wcnt <= wcnt + 1'b1;
    end
  end

  assign last = (idx == BIN_WIDTH'(NUM_BINS - 1));
  assign xfer = (state == S_STREAM) && bin_if.bin_ready;

  // The final beat frees the shadow, so a coinciding window
  // end reloads it instead of counting as an overrun.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load     = 1'b0;
    ovr_nx   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (window_end) begin
          load     = 1'b1;
          idx_nx   = '0;
          state_nx = S_STREAM;
        end
      end
      S_STREAM: begin
        if (xfer) idx_nx = idx + 1'b1;
        if (xfer && last) begin
          if (window_end) load = 1'b1;
          else            state_nx = S_IDLE;
        end else if (window_end) begin
          ovr_nx = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) shadow[i] <= '0;
    end else begin
      idx     <= idx_nx;
      overrun <= ovr_nx;
      if (load) begin
        for (int i = 0; i < NUM_BINS; i++)
          shadow[i] <= live_nx[i];
      end
    end
  end

  assign bin_if.bin_valid = (state == S_STREAM);
  assign bin_if.bin_index = idx;
  assign bin_if.bin_count = shadow[idx];
  assign bin_if.bin_last  = (state == S_STREAM) && last;

endmodule

// File: tb/tb_dtree_class_binner.sv
// Scoreboard bench for dtree_class_binner (WINDOW_LEN=4, 4-bit counts).
// A behavioural histogram model predicts every streamed word.
module tb_dtree_class_binner;
  import dtree_pkg::*;

  localparam int CW = 4;
  localparam int NB = 16;
  localparam int WL = 4;
  localparam int CMAX = 15;

  typedef struct packed {
    bin_idx_t        idx;
    logic [CW-1:0]   cnt;
    logic            last;
  } word_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] level = '0;
  logic [1:0] path = '0;
  logic       overrun;

  dtree_class_binner_if #(
    .BIN_WIDTH(4),
    .COUNT_WIDTH(CW)
  ) bif ();

  dtree_class_binner #(
    .LEVEL_WIDTH(2),
    .PATH_WIDTH(2),
    .COUNT_WIDTH(CW),
    .WINDOW_LEN(WL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .level   (level),
    .path    (path),
    .in_valid(in_valid),
    .overrun (overrun),
    .bin_if  (bif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int    m_live [NB];
  int    m_wcnt, m_rem, exp_ovr, ovr_seen, cyc_n;
  word_t exp_q [$];
  word_t obs_q [$];
  int    obs_cyc [$];

  // One clock: drive inputs, log a transfer, advance model.
  task automatic step(input logic t, input logic v,
                      input logic [1:0] l,
                      input logic [1:0] p,
                      input logic r);
    word_t w;
    tick = t;
    in_valid = v;
    level = l;
    path = p;
    bif.bin_ready = r;
    #1;
    if (bif.bin_valid && r) begin
      w.idx = bif.bin_index;
      w.cnt = bif.bin_count;
      w.last = bif.bin_last;
      obs_q.push_back(w);
      obs_cyc.push_back(cyc_n);
    end
    if (m_rem > 0 && r) m_rem--;
    if (v && m_live[{l, p}] < CMAX) m_live[{l, p}]++;
    if (t) begin
      if (m_wcnt == WL - 1) begin
        m_wcnt = 0;
        if (m_rem == 0) begin
          for (int i = 0; i < NB; i++) begin
            w.idx = bin_idx_t'(i);
            w.cnt = CW'(m_live[i]);
            w.last = (i == NB - 1);
            exp_q.push_back(w);
          end
          m_rem = NB;
        end else begin
          exp_ovr++;
        end
        for (int i = 0; i < NB; i++) m_live[i] = 0;
      end else begin
        m_wcnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    ovr_seen += int'(overrun);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick = 1'b0;
    in_valid = 1'b0;
    level = '0;
    path = '0;
    bif.bin_ready = 1'b0;
    for (int i = 0; i < NB; i++) m_live[i] = 0;
    m_wcnt = 0;
    m_rem = 0;
    exp_ovr = 0;
    ovr_seen = 0;
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bif.bin_valid, bif.bin_last, bif.bin_index,
         bif.bin_count, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_held got v=%0b l=%0b i=%0d c=%0d o=%0b want all 0",
               bif.bin_valid, bif.bin_last, bif.bin_index,
               bif.bin_count, overrun);
    end
    do_reset();
    #1;
    checks++;
    if ({bif.bin_valid, bif.bin_last, bif.bin_index,
         bif.bin_count, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_release got v=%0b l=%0b i=%0d c=%0d o=%0b want all 0",
               bif.bin_valid, bif.bin_last, bif.bin_index,
               bif.bin_count, overrun);
    end
    @(negedge clk);
    for (int k = 0; k < WL - 1; k++) begin
      step(1, 0, 0, 0, 1);
      checks++;
      if (bif.bin_valid !== 1'b0) begin
        errors++;
        $display("FAIL early_valid tick %0d got %0b want 0",
                 k + 1, bif.bin_valid);
      end
    end
    step(1, 0, 0, 0, 1);
    checks++;
    if ({bif.bin_valid, bif.bin_index} !== 5'b1_0000) begin
      errors++;
      $display("FAIL first_latency got v=%0b i=%0d want v=1 i=0",
               bif.bin_valid, bif.bin_index);
    end
    repeat (NB + 1) step(0, 0, 0, 0, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_len got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_word[%0d] got %p want %p",
                 i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_basic();
    step(1, 1, 2'd1, 2'd1, 1);
    step(1, 1, 2'd1, 2'd1, 1);
    step(1, 1, 2'd2, 2'd3, 1);
    step(1, 0, 0, 0, 1);
    repeat (NB + 1) step(0, 0, 0, 0, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_len got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_word[%0d] got %p want %p",
                 i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_cyc.size() == NB) begin
      checks++;
      if (obs_cyc[NB-1] - obs_cyc[0] != NB - 1) begin
        errors++;
        $display("FAIL back_to_back got span %0d want %0d",
                 obs_cyc[NB-1] - obs_cyc[0], NB - 1);
      end
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_saturate();
    repeat (20) step(0, 1, 2'd0, 2'd3, 1);
    repeat (WL) step(1, 0, 0, 0, 1);
    repeat (NB + 1) step(0, 0, 0, 0, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sat_len got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sat_word[%0d] got %p want %p",
                 i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_overrun();
    step(1, 1, 2'd1, 2'd1, 1);
    step(1, 1, 2'd1, 2'd1, 1);
    step(1, 1, 2'd2, 2'd3, 1);
    step(1, 0, 0, 0, 0);
    step(1, 1, 2'd0, 2'd0, 0);
    step(1, 1, 2'd0, 2'd0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    checks++;
    if (ovr_seen !== exp_ovr) begin
      errors++;
      $display("FAIL overrun_pulse got %0d cycles want %0d",
               ovr_seen, exp_ovr);
    end
    checks++;
    if (exp_q.size() > 0 &&
        ({bif.bin_valid, bif.bin_index, bif.bin_count} !==
         {1'b1, exp_q[0].idx, exp_q[0].cnt})) begin
      errors++;
      $display("FAIL stall_hold got v=%0b i=%0d c=%0d want v=1 i=%0d c=%0d",
               bif.bin_valid, bif.bin_index, bif.bin_count,
               exp_q[0].idx, exp_q[0].cnt);
    end
    repeat (NB + 1) step(0, 0, 0, 0, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ovr_len got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ovr_word[%0d] got %p want %p",
                 i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_edge_event();
    repeat (WL - 1) step(1, 0, 0, 0, 1);
    step(1, 1, 2'd1, 2'd2, 1);
    step(1, 1, 2'd1, 2'd2, 1);
    repeat (NB) step(0, 0, 0, 0, 1);
    repeat (WL - 1) step(1, 0, 0, 0, 1);
    repeat (NB + 1) step(0, 0, 0, 0, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL edge_len got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL edge_word[%0d] got %p want %p",
                 i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovr_seen !== exp_ovr) begin
      errors++;
      $display("FAIL edge_overrun got %0d want %0d",
               ovr_seen, exp_ovr);
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_mid_reset();
    step(1, 1, 2'd2, 2'd1, 1);
    step(1, 1, 2'd2, 2'd1, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    repeat (7) step(0, 0, 0, 0, 1);
    checks++;
    if ({bif.bin_valid, bif.bin_index} !== 5'b1_0111) begin
      errors++;
      $display("FAIL pre_abort got v=%0b i=%0d want v=1 i=7",
               bif.bin_valid, bif.bin_index);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bif.bin_valid, bif.bin_last, bif.bin_index,
         bif.bin_count, overrun} !== '0) begin
      errors++;
      $display("FAIL async_abort got v=%0b l=%0b i=%0d c=%0d o=%0b want all 0",
               bif.bin_valid, bif.bin_last, bif.bin_index,
               bif.bin_count, overrun);
    end
    do_reset();
    step(1, 1, 2'd3, 2'd0, 1);
    repeat (WL - 1) step(1, 0, 0, 0, 1);
    repeat (NB + 1) step(0, 0, 0, 0, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_len got %0d want %0d",
               obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_word[%0d] got %p want %p",
                 i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    bif.bin_ready = 1'b0;
    cyc_n = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_overrun();
    test_edge_event();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
